vdc_signals_h: RTL and testbench

// - Horizontal timing generator for the 8563/8568 VDC. Counts dots within a character
//   and characters within a scanline from R0/R1/R2/R3/R22/R25.
// - Emits one-enable-wide line strobes (lineStart, displayStart, half1End, half2Start,

---
 rtl/vdc_pkg.sv | 23 ++
 rtl/vdc_signals_h.sv | 113 +++++++++++
 tb/tb_vdc_signals_h.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vdc_pkg.sv
// Shared constants and types for the VDC timing generators.
// Register field widths and the default hsync width used when R3 width is zero.
package vdc_pkg;

  localparam int REG_CHR_W        = 8;
  localparam int REG_DOT_W        = 4;
  localparam int HSW_ZERO_DEFAULT = 16;

  typedef struct packed {
    logic line_start;
    logic display_start;
    logic half1_end;
    logic half2_start;
    logic hsync_start;
    logic line_end;
  } h_strobe_t;

  // Middle column of the line, computed one bit wider so ht=255 does not overflow.
  function automatic logic [REG_CHR_W:0] half_col(input logic [REG_CHR_W-1:0] ht);
    return ({1'b0, ht} + 9'd1) >> 1;
  endfunction

endpackage

// File: rtl/vdc_signals_h.sv
// Horizontal timing generator: dot/column counters, one-enable line strobes,
// hsync width counter and horizontal display window.
module vdc_signals_h
  import vdc_pkg::*;
#(
  parameter int HSW_ZERO = HSW_ZERO_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [REG_CHR_W-1:0] reg_ht,
  input  logic [REG_CHR_W-1:0] reg_hd,
  input  logic [REG_CHR_W-1:0] reg_hp,
  input  logic [3:0]           reg_hw,
  input  logic [REG_DOT_W-1:0] reg_ctp,
  input  logic                 reg_dbl,
  output logic                 lineStart,
  output logic                 displayStart,
  output logic                 half1End,
  output logic                 half2Start,
  output logic                 hSyncStart,
  output logic                 lineEnd,
  output logic                 hsync,
  output logic                 hVisible,
  output logic [REG_CHR_W-1:0] col,
  output logic [REG_DOT_W-1:0] dot
);

  logic [REG_CHR_W-1:0] col_reg, col_next;
  logic [REG_DOT_W-1:0] dot_reg, dot_next;
  logic                 phase_reg, phase_next;
  logic [4:0]           hs_count_reg, hs_count_next;
  logic                 hvis_reg, hvis_next;
  h_strobe_t            strobe_reg, strobe_next;

  logic                 last_dot;
  logic                 dot_zero;
  logic [REG_CHR_W:0]   col9;
  logic [REG_CHR_W:0]   half_col9;
  logic [REG_CHR_W:0]   hd_end9;

  always_comb begin
    // In pixel-double mode each dot spans phase 0 then phase 1; the dot
    // counter steps on phase 1 so lastDot is always the step before dot 0.
    last_dot  = (dot_reg >= reg_ctp) && (!reg_dbl || phase_reg);
    dot_zero  = (dot_reg == '0) && !phase_reg;
    col9      = {1'b0, col_reg};
    half_col9 = half_col(reg_ht);
    hd_end9   = {1'b0, reg_hd} + 9'd1;

    strobe_next.line_start    = (col_reg == '0) && dot_zero;
    strobe_next.display_start = (col_reg == 8'd1) && dot_zero;
    strobe_next.half1_end     = ((col9 + 9'd1) == half_col9) && last_dot;
    strobe_next.half2_start   = (col9 == half_col9) && dot_zero;
    strobe_next.hsync_start   = (col_reg == reg_hp) && dot_zero;
    strobe_next.line_end      = (col_reg >= reg_ht) && last_dot;

    phase_next = reg_dbl ? ~phase_reg : 1'b0;
    dot_next   = dot_reg;
    col_next   = col_reg;
    if (last_dot) begin
      dot_next = '0;
      col_next = (col_reg >= reg_ht) ? '0 : col_reg + 8'd1;
    end else if (!reg_dbl || phase_reg) begin
      dot_next = dot_reg + 4'd1;
    end

    hs_count_next = hs_count_reg;
    if (strobe_next.hsync_start) begin
      hs_count_next = (reg_hw != 4'd0) ? {1'b0, reg_hw} : 5'(HSW_ZERO);
    end else if (dot_zero && (hs_count_reg != 5'd0)) begin
      hs_count_next = hs_count_reg - 5'd1;
    end

    // Clearing at column 0 also covers a window wider than the line.
    hvis_next = hvis_reg;
    if (dot_zero && ((col9 == hd_end9) || (col_reg == '0))) begin
      hvis_next = 1'b0;
    end else if (strobe_next.display_start && (reg_hd != '0)) begin
      hvis_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_reg      <= '0;
      dot_reg      <= '0;
      phase_reg    <= 1'b0;
      hs_count_reg <= '0;
      hvis_reg     <= 1'b0;
      strobe_reg   <= '0;
    end else if (enable) begin
      col_reg      <= col_next;
      dot_reg      <= dot_next;
      phase_reg    <= phase_next;
      hs_count_reg <= hs_count_next;
      hvis_reg     <= hvis_next;
      strobe_reg   <= strobe_next;
    end
  end

  assign lineStart    = strobe_reg.line_start;
  assign displayStart = strobe_reg.display_start;
  assign half1End     = strobe_reg.half1_end;
  assign half2Start   = strobe_reg.half2_start;
  assign hSyncStart   = strobe_reg.hsync_start;
  assign lineEnd      = strobe_reg.line_end;
  assign hsync        = |hs_count_reg;
  assign hVisible     = hvis_reg;
  assign col          = col_reg;
  assign dot          = dot_reg;

endmodule

// File: tb/tb_vdc_signals_h.sv
// Self-checking bench for vdc_signals_h: table-driven line measurements,
// hand-written corner sequences and randomized runs against a position model.
module tb_vdc_signals_h;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] reg_ht, reg_hd, reg_hp;
  logic [3:0] reg_hw, reg_ctp;
  logic       reg_dbl;
  logic       lineStart, displayStart, half1End, half2Start, hSyncStart, lineEnd;
  logic       hsync, hVisible;
  logic [7:0] col;
  logic [3:0] dot;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vdc_signals_h dut (
    .clk(clk), .reset(reset), .enable(enable),
    .reg_ht(reg_ht), .reg_hd(reg_hd), .reg_hp(reg_hp), .reg_hw(reg_hw),
    .reg_ctp(reg_ctp), .reg_dbl(reg_dbl),
    .lineStart(lineStart), .displayStart(displayStart), .half1End(half1End),
    .half2Start(half2Start), .hSyncStart(hSyncStart), .lineEnd(lineEnd),
    .hsync(hsync), .hVisible(hVisible), .col(col), .dot(dot)
  );

  typedef struct {
    int ht, hd, hp, hw, ctp, dbl;
    int exp_period, exp_hs, exp_vis;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [19:0] dut_vec();
    return {lineStart, displayStart, half1End, half2Start, hSyncStart, lineEnd,
            hsync, hVisible, col, dot};
  endfunction

  // Expected outputs after k enabled clocks since reset, from line geometry alone:
  // strobes reflect the position decoded at enable k-1, counters show position k.
  function automatic logic [19:0] model_vec(input int k);
    int ht, hd, hp, w, cl, lw, n, p, c, wi, half, a, vis_end, p2;
    logic ls, ds, h1, h2, hss, le, hs, vis;
    logic [7:0] c2;
    logic [3:0] d2;
    ht = int'(reg_ht); hd = int'(reg_hd); hp = int'(reg_hp);
    w  = (reg_hw != 0) ? int'(reg_hw) : 16;
    cl = (int'(reg_ctp) + 1) * (reg_dbl ? 2 : 1);
    lw = (ht + 1) * cl;
    p2 = k % lw;
    c2 = 8'(p2 / cl);
    d2 = 4'((p2 % cl) / (reg_dbl ? 2 : 1));
    if (k == 0) return {12'd0, c2, d2};
    n = k - 1;
    p = n % lw;
    c = p / cl;
    wi = p % cl;
    a = n / cl;
    half = (ht + 1) / 2;
    ls  = (c == 0) && (wi == 0);
    ds  = (c == 1) && (wi == 0);
    h1  = (c == half - 1) && (wi == cl - 1);
    h2  = (c == half) && (wi == 0);
    hss = (c == hp) && (wi == 0);
    le  = (c == ht) && (wi == cl - 1);
    hs  = (hp <= ht) && (a >= hp) && (((c - hp + ht + 1) % (ht + 1)) < w);
    vis_end = (hd < ht) ? hd : ht;
    vis = (c >= 1) && (c <= vis_end);
    return {ls, ds, h1, h2, hss, le, hs, vis, c2, d2};
  endfunction

  task automatic set_cfg(input int ht, hd, hp, hw, ctp, dbl);
    reg_ht = 8'(ht); reg_hd = 8'(hd); reg_hp = 8'(hp);
    reg_hw = 4'(hw); reg_ctp = 4'(ctp); reg_dbl = dbl[0];
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_ls(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (lineStart) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
  endtask

  // Starting at a negedge with lineStart high, sample one whole line.
  task automatic measure_line(output int per, output int hs, output int vis,
                              output int le_last, output int hss_first);
    per = 0; hs = 0; vis = 0; le_last = 0;
    hss_first = int'(hSyncStart);
    for (int i = 0; i < 5000; i++) begin
      per++;
      hs += int'(hsync);
      vis += int'(hVisible);
      le_last = int'(lineEnd);
      @(negedge clk);
      if (lineStart) break;
    end
  endtask

  vec_t vecs[8];

  initial begin
    bit ok;
    int per, hs, vis, le_last, hss_first, k;

    vecs[0] = '{126, 80, 102, 9, 7, 0, 1016, 72, 640};
    vecs[1] = '{126, 80, 102, 9, 7, 1, 2032, 144, 1280};
    vecs[2] = '{126, 80, 102, 0, 7, 0, 1016, 128, 640};
    vecs[3] = '{126, 80, 0, 9, 7, 0, 1016, 72, 640};
    vecs[4] = '{126, 80, 200, 9, 7, 0, 1016, 0, 640};
    vecs[5] = '{126, 0, 102, 9, 7, 0, 1016, 72, 0};
    vecs[6] = '{10, 20, 3, 2, 3, 0, 44, 8, 40};
    vecs[7] = '{0, 0, 0, 0, 0, 0, 1, 1, 0};

    set_cfg(126, 80, 102, 9, 7, 0);
    repeat (3) @(negedge clk);
    chk("reset_state", int'(dut_vec()), 0);

    // Table: steady-state line measurements.
    for (int v = 0; v < 8; v++) begin
      set_cfg(vecs[v].ht, vecs[v].hd, vecs[v].hp, vecs[v].hw, vecs[v].ctp, vecs[v].dbl);
      do_reset();
      enable = 1'b1;
      wait_ls("tbl_first_ls", ok);
      wait_ls("tbl_second_ls", ok);
      measure_line(per, hs, vis, le_last, hss_first);
      chk($sformatf("tbl%0d_period", v), per, vecs[v].exp_period);
      chk($sformatf("tbl%0d_hsync", v), hs, vecs[v].exp_hs);
      chk($sformatf("tbl%0d_hvisible", v), vis, vecs[v].exp_vis);
      chk($sformatf("tbl%0d_lineend_before_ls", v), le_last, 1);
      chk($sformatf("tbl%0d_hss_with_ls", v), hss_first, (vecs[v].hp == 0) ? 1 : 0);
      $display("vector %0d: period=%0d hsync=%0d hvisible=%0d", v, per, hs, vis);
    end

    // Half-line strobes: decode at col 62 dot 7 / col 63 dot 0.
    set_cfg(126, 80, 102, 9, 7, 0);
    do_reset();
    enable = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 2100; i++) begin
      @(negedge clk);
      if (half1End) begin ok = 1'b1; break; end
    end
    chk("half1end_seen", int'(ok), 1);
    chk("half1end_pos", {col, dot}, {8'd63, 4'd0});
    @(negedge clk);
    chk("half2start_strobe", int'(half2Start), 1);
    chk("half2start_pos", {col, dot}, {8'd63, 4'd1});
    $display("half strobes checked at col=%0d dot=%0d", col, dot);

    // Live R0 write below the current column ends the line at that column.
    ok = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (col == 8'd100) begin ok = 1'b1; break; end
    end
    chk("col100_reached", int'(ok), 1);
    reg_ht = 8'd40;
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (lineEnd) begin ok = 1'b1; break; end
    end
    chk("live_ht_lineend", int'(ok), 1);
    chk("live_ht_wrap_pos", {col, dot}, 12'd0);
    @(negedge clk);
    chk("live_ht_linestart", int'(lineStart), 1);
    measure_line(per, hs, vis, le_last, hss_first);
    chk("live_ht_next_period", per, 328);
    $display("live ht write: next line period=%0d", per);

    // Reset mid-line, then release with enable low.
    reset = 1'b1;
    @(negedge clk);
    chk("midline_reset_zero", int'(dut_vec()), 0);
    reset = 1'b0;
    enable = 1'b0;
    @(negedge clk);
    chk("post_reset_hold", int'(dut_vec()), 0);
    enable = 1'b1;
    @(negedge clk);
    chk("first_ls_after_enable", int'(lineStart), 1);
    $display("mid-line reset: lineStart=%0d after first enable", lineStart);

    // Randomized configurations with random enable gaps.
    for (int t = 0; t < 8; t++) begin
      set_cfg($urandom_range(0, 12), $urandom_range(0, 15), $urandom_range(0, 16),
              $urandom_range(0, 15), $urandom_range(0, 5), $urandom_range(0, 1));
      do_reset();
      k = 0;
      for (int i = 0; i < 600; i++) begin
        @(negedge clk);
        chk($sformatf("rand%0d_step%0d", t, i), int'(dut_vec()), int'(model_vec(k)));
        enable = ($urandom_range(0, 3) != 0);
        @(posedge clk);
        if (enable) k++;
      end
      $display("random cfg %0d: ht=%0d hd=%0d hp=%0d hw=%0d ctp=%0d dbl=%0d enables=%0d",
               t, reg_ht, reg_hd, reg_hp, reg_hw, reg_ctp, reg_dbl, k);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
